dmem_responder: RTL and testbench

Synthesizable data-memory responder for the single-cycle/multi-cycle RISC-V core's data port. It answers core load/store requests over a req/ready handshake with a programmable number of wait states. It decodes each address into one of two word-addressed windows, data and stack, each placed at a runtime base address. It replaces the zero-latency behavioural memory so that core stall logic can be exercised against a realistic, slow responder.

---
 rtl/dmem_if.sv | 12 +
 rtl/dmem_responder.sv | 85 ++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: core data-port request/response bundle
interface dmem_if;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  modport master(output mem_req, mem_wen, mem_addr, mem_wdata, input mem_rdata, mem_ready, mem_err);
  modport slave(input mem_req, mem_wen, mem_addr, mem_wdata, output mem_rdata, mem_ready, mem_err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data/stack window memory; define DMEM_RANGE_CHK_EN for miss/misalign errors
module dmem_responder #(
  parameter int DATA_WORDS  = 32,
  parameter int STACK_WORDS = 32,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_base,
  input  logic [31:0] stack_base,
  dmem_if.slave       bus
);
  localparam int DW = DATA_WORDS > 1 ? $clog2(DATA_WORDS) : 1;
  localparam int SW = STACK_WORDS > 1 ? $clog2(STACK_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      st, st_n;
  logic [3:0]  cnt;
  logic        wen_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] dmem [DATA_WORDS];
  logic [31:0] smem [STACK_WORDS];
  logic        wen_e;
  logic [31:0] addr_e, wdata_e, d_idx, s_idx, rd;
  logic        d_hit, s_hit, d_sel, s_sel, acc_ok, err, fire;
  logic [DW-1:0] di;
  logic [SW-1:0] si;
  always_comb begin
    st_n = st == IDLE ? (bus.mem_req ? (LATENCY == 1 ? DONE : WAIT) : IDLE) :
           st == WAIT ? (cnt <= 4'd1 ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    wen_e   = st == IDLE ? bus.mem_wen   : wen_q;
    addr_e  = st == IDLE ? bus.mem_addr  : addr_q;
    wdata_e = st == IDLE ? bus.mem_wdata : wdata_q;
    d_idx   = (addr_e - data_base) >> 2;
    s_idx   = (addr_e - stack_base) >> 2;
    d_hit   = addr_e >= data_base && d_idx < 32'(DATA_WORDS);
    s_hit   = !d_hit && addr_e >= stack_base && s_idx < 32'(STACK_WORDS);
    si      = SW'(s_idx);
`ifdef DMEM_RANGE_CHK_EN
    acc_ok  = addr_e[1:0] == 2'b00;
    err     = !(d_hit || s_hit) || !acc_ok;
    d_sel   = d_hit;
    di      = DW'(d_idx);
`else
    acc_ok  = 1'b1;
    err     = 1'b0;
    d_sel   = !s_hit;
    di      = DW'(d_idx % 32'(DATA_WORDS));
`endif
    s_sel   = s_hit;
    rd      = !acc_ok || wen_e ? '0 : d_sel ? dmem[di] : s_sel ? smem[si] : '0;
    fire    = st != DONE && st_n == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      cnt     <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DATA_WORDS; i++) dmem[i] <= '0;
      for (int i = 0; i < STACK_WORDS; i++) smem[i] <= '0;
    end else begin
      st <= st_n;
      if (st == IDLE && bus.mem_req) begin
        wen_q   <= bus.mem_wen;
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (st == WAIT) cnt <= cnt - 4'd1;
      if (fire) begin
        rdata_q <= rd;
        err_q   <= err;
        if (wen_e && acc_ok && d_sel) dmem[di] <= wdata_e;
        else if (wen_e && acc_ok && s_sel) smem[si] <= wdata_e;
      end
    end
  end
  assign bus.mem_ready = st == DONE;
  assign bus.mem_rdata = st == DONE ? rdata_q : '0;
  assign bus.mem_err   = st == DONE && err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized bench for dmem_responder against a word-array reference model
module tb_dmem_responder;
  localparam logic [31:0] DB = 32'h0001_0088;
  localparam logic [31:0] SB = 32'hBFFF_FF74;
  logic clk, rst_n;
  logic [31:0] data_base, stack_base;
  logic [31:0] dm [32];
  logic [31:0] sm [32];
  int tests, fails, cyc;
  dmem_if ia();
  dmem_if ib();
  dmem_responder #(.DATA_WORDS(32), .STACK_WORDS(32), .LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_base(data_base), .stack_base(stack_base), .bus(ia));
  dmem_responder #(.DATA_WORDS(32), .STACK_WORDS(32), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_base(data_base), .stack_base(stack_base), .bus(ib));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      dm[i] = '0;
      sm[i] = '0;
    end
  endtask
  task automatic model(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    logic [31:0] d, s;
    logic dh, sh, mis;
    d = (a - DB) / 4;
    s = (a - SB) / 4;
    dh = a >= DB && d < 32;
    sh = !dh && a >= SB && s < 32;
    mis = a[1:0] != 2'b00;
    rd = '0;
`ifdef DMEM_RANGE_CHK_EN
    err = mis || !(dh || sh);
    if (!err && dh) begin
      if (wen) dm[d[4:0]] = wd;
      else rd = dm[d[4:0]];
    end else if (!err && sh) begin
      if (wen) sm[s[4:0]] = wd;
      else rd = sm[s[4:0]];
    end
`else
    err = 1'b0;
    if (sh) begin
      if (wen) sm[s[4:0]] = wd;
      else rd = sm[s[4:0]];
    end else begin
      if (wen) dm[d % 32] = wd;
      else rd = dm[d % 32];
    end
`endif
  endtask
  task automatic access(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                        input logic scramble, input string nm);
    logic [31:0] erd;
    logic eerr;
    int st;
    model(wen, a, wd, erd, eerr);
    ia.mem_req = 1'b1;
    ia.mem_wen = wen;
    ia.mem_addr = a;
    ia.mem_wdata = wd;
    st = cyc;
    do begin
      @(negedge clk);
      if (scramble && cyc > st) begin
        ia.mem_wen = 1'($urandom);
        ia.mem_addr = $urandom;
        ia.mem_wdata = $urandom;
      end
    end while (!ia.mem_ready && cyc - st < 40);
    tests++;
    if (!ia.mem_ready) begin
      fails++;
      $display("FAIL %s timeout: mem_ready never seen, required within 2 cycles", nm);
    end else begin
      tests++;
      if (cyc - st !== 2) begin
        fails++;
        $display("FAIL %s latency: got %0d cycles, required 2", nm, cyc - st);
      end
      tests++;
      if (ia.mem_err !== eerr) begin
        fails++;
        $display("FAIL %s err: got %b, required %b", nm, ia.mem_err, eerr);
      end
      if (!wen) begin
        tests++;
        if (ia.mem_rdata !== erd) begin
          fails++;
          $display("FAIL %s rdata: got %h, required %h", nm, ia.mem_rdata, erd);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ia.mem_req = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({ia.mem_ready, ia.mem_err, ia.mem_rdata, ib.mem_ready, ib.mem_err, ib.mem_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got a=%b/%b/%h b=%b/%b/%h, required all 0",
               ia.mem_ready, ia.mem_err, ia.mem_rdata, ib.mem_ready, ib.mem_err, ib.mem_rdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    access(1'b0, DB, '0, 1'b0, "reset_load");
    idle();
  endtask
  task automatic test_store_load();
    access(1'b1, DB, 32'hDEADBEEF, 1'b0, "store_deadbeef");
    access(1'b0, DB, '0, 1'b0, "load_deadbeef");
    idle();
  endtask
  task automatic test_stack();
    access(1'b1, 32'hBFFFFFF0, 32'h12345678, 1'b0, "stack_store");
    access(1'b0, 32'hBFFFFFF0, '0, 1'b0, "stack_load");
    access(1'b0, DB + 32'd124, '0, 1'b0, "data_idx31_untouched");
    idle();
  endtask
  task automatic test_range();
    access(1'b0, 32'h00010108, '0, 1'b0, "load_idx32");
    access(1'b1, 32'h0001008A, 32'h55AA55AA, 1'b0, "store_misaligned");
    access(1'b0, DB, '0, 1'b0, "load_after_misaligned");
    idle();
  endtask
  task automatic test_reset_mid();
    ia.mem_req = 1'b1;
    ia.mem_wen = 1'b1;
    ia.mem_addr = 32'h0001008C;
    ia.mem_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 rst_n = 1'b0;
    ia.mem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (ia.mem_ready !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_ready: got %b at cycle %0d, required 0", ia.mem_ready, i);
      end
    end
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, 32'h0001008C, '0, 1'b0, "reset_mid_load");
    idle();
  endtask
  task automatic test_back_to_back();
    ib.mem_req = 1'b1;
    ib.mem_wen = 1'b0;
    ib.mem_addr = DB;
    ib.mem_wdata = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (ib.mem_ready !== 1'(i % 2)) begin
        fails++;
        $display("FAIL lat1_ready cycle %0d: got %b, required %b", i, ib.mem_ready, 1'(i % 2));
      end
    end
    @(posedge clk);
    #1 ib.mem_req = 1'b0;
    @(negedge clk);
    tests++;
    if (ib.mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL lat1_after_drop: got %b, required 0", ib.mem_ready);
    end
  endtask
  task automatic test_random();
    logic [31:0] a;
    logic [5:0] idx;
    for (int n = 0; n < 60; n++) begin
      idx = 6'($urandom_range(0, 33));
      case ($urandom_range(0, 3))
        0: a = DB + {24'd0, idx, 2'b00};
        1: a = SB + {24'd0, idx, 2'b00};
        2: a = $urandom;
        default: a = DB + {24'd0, idx, 2'b00} + 32'($urandom_range(1, 3));
      endcase
      access(1'($urandom), a, $urandom, 1'($urandom), "random");
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
  endtask
  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    rst_n = 1'b0;
    data_base = DB;
    stack_base = SB;
    ia.mem_req = 1'b0;
    ia.mem_wen = 1'b0;
    ia.mem_addr = '0;
    ia.mem_wdata = '0;
    ib.mem_req = 1'b0;
    ib.mem_wen = 1'b0;
    ib.mem_addr = '0;
    ib.mem_wdata = '0;
    test_reset();
    test_store_load();
    test_stack();
    test_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
